// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: sums DIGIT bits per cycle over N = WIDTH/DIGIT cycles,
// with a valid/ready handshake on both operand and result sides.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, step, last;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dsum;
  logic             c_msb;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    case (state)
      IDLE:    accept = in_valid;
      RUN:     step   = 1'b1;
      default: ;
    endcase
  end

  assign last = (cnt_q == CW'(N - 1));

  // Select the active operand digit with constant slices only
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // One digit of addition; carry into the MSB is recovered from the sum bit
  always_comb begin
    dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    c_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
  end

  // Operand capture; subtract mode is folded into inverted B and carry-in of 1
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= SUB ? ~B : B;
      carry_q <= SUB ? 1'b1 : Cin;
      cnt_q   <= '0;
    end else if (step) begin
      carry_q <= dsum[DIGIT];
      if (!last) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers: Sum fills digit by digit, flags captured on the final digit
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovf  <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < int'(N); i++) begin
        if (cnt_q == CW'(i)) Sum[i*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
      end
      if (last) begin
        Cout <= dsum[DIGIT];
        Ovf  <= c_msb ^ dsum[DIGIT];
      end
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 8: bits summed per cycle. WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be at least 1.
REQ-003 The block SHALL have derived constant N = WIDTH/DIGIT: digit count, which is also the compute latency in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 The block SHALL have ports A and B, input, WIDTH bits each: operands.
REQ-009 The block SHALL have port Cin, input, 1 bit: carry-in, used in add mode only.
REQ-010 The block SHALL have port SUB, input, 1 bit: 0 = A+B+Cin; 1 = A-B (A + ~B + 1, Cin ignored).
REQ-011 The block SHALL have port out_valid, output, 1 bit: result held and valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-013 The block SHALL have port Sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-014 The block SHALL have port Cout, output, 1 bit: carry out of the MSB. In SUB mode, 1 means no borrow.
REQ-015 The block SHALL have port Ovf, output, 1 bit: two's-complement overflow, equal to carry into MSB XOR carry out of MSB.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE. in_ready SHALL be 1 in IDLE only. out_valid SHALL be 1 in DONE only.
REQ-017 Accept rule: when state is IDLE and in_valid=1 at an edge, the block SHALL register A, B and mode. It SHALL register B already inverted when SUB=1. It SHALL initialise the carry register to Cin (add) or 1 (SUB). It SHALL clear the digit counter and enter RUN.
REQ-018 In IDLE with in_valid=0, the block SHALL hold all outputs unchanged. This keeps the previous Sum, Cout and Ovf visible.
REQ-019 In RUN, each cycle k (k = 0..N-1) SHALL add operand digit k, bits [k*DIGIT +: DIGIT], plus the carry register.
REQ-020 Each RUN cycle SHALL write the digit result into Sum bits [k*DIGIT +: DIGIT], update the carry register with the digit carry-out, and increment k.
REQ-021 On the edge where k=N-1 is processed, the block SHALL capture Cout (the final carry) and Ovf (carry into the MSB XOR carry out of the MSB), and enter DONE.
REQ-022 Latency: when operands are accepted at edge T, out_valid SHALL go to 1 after edge T+N. For example, N=4 at defaults.
REQ-023 In DONE, Sum, Cout and Ovf SHALL stay stable while out_ready=0, for any number of cycles.
REQ-024 In DONE with out_ready=1 at an edge, the block SHALL return to IDLE. out_valid SHALL be 0 and in_ready SHALL be 1 after that edge.
REQ-025 While in RUN or DONE, in_valid SHALL be ignored and operands SHALL NOT be sampled. A and B may change freely without affecting the result.
REQ-026 Accepting new operands and delivering a result SHALL NOT happen in the same cycle. Peak throughput is one operation per N+2 cycles.
REQ-027 When DIGIT=WIDTH, N=1 and the block SHALL behave as a single-cycle registered adder with the same handshake.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE and clear the digit counter and the carry register.
REQ-029 When rst=1 at an edge, the block SHALL reset Sum to 0, Cout to 0, Ovf to 0 and out_valid to 0; in_ready SHALL be 1 after the edge.
REQ-030 Reset SHALL have priority over every other event, including accept and the out_ready handshake. An operation in progress in RUN or DONE SHALL be aborted with no result delivered.

Verification
REQ-031 The bench SHALL check at defaults: A=0xFFFFFFFF, B=0x00000001, Cin=0, SUB=0 -> out_valid 4 cycles after accept, Sum=0x00000000, Cout=1, Ovf=0.
REQ-032 The bench SHALL check: A=0x7FFFFFFF, B=0x00000001, Cin=0, SUB=0 -> Sum=0x80000000, Cout=0, Ovf=1.
REQ-033 The bench SHALL check: A=5, B=7, SUB=1, Cin=1 (ignored) -> Sum=0xFFFFFFFE, Cout=0, Ovf=0. It SHALL also check A=7, B=5, SUB=1 -> Sum=0x00000002, Cout=1.
REQ-034 The bench SHALL check backpressure: out_ready=0 for 6 cycles in DONE while in_valid=1 with new operands -> out_valid and Sum stay constant, in_ready=0, and the new operands are not taken. Raising out_ready -> IDLE next cycle.
REQ-035 The bench SHALL check reset mid-operation: assert rst for one cycle at RUN digit 2 -> next cycle out_valid=0, in_ready=1, Sum=0. The following A=3, B=4 add then yields Sum=7.
REQ-036 The bench SHALL check WIDTH=4, DIGIT=1: A=0xF, B=0xF, Cin=1 -> Sum=0xF, Cout=1, Ovf=0, with latency 4. It SHALL also check WIDTH=DIGIT=8: 0x80+0x80 -> Sum=0x00, Cout=1, Ovf=1, with latency 1.
